midi_msg_parser: RTL and testbench
==================================

// Module: midi_msg_parser
// PURPOSE
//  Consumes the byte stream from the MIDI UART receiver (one strobe per byte).
//  Assembles complete MIDI channel and system-common messages, with running status.
//  Passes system real-time bytes through on a separate low-latency path.
//  Sits between the MIDI UART receiver and the synth voice/controller MMIO logic.
// PARAMETERS
//  NOTE_ON_ZERO_AS_OFF  1  1: Note-On (9n) with velocity 0 is emitted as Note-Off (8n), vel 0
// PORTS
//  clk_i            in   1  system clock
//  rst_i            in   1  reset, asynchronous, active-high
//  byte_valid_i     in   1  one-cycle strobe: byte_i holds a received byte (UART rx_done)
//  byte_i           in   8  received byte (UART data)
//  msg_valid_o      out  1  one-cycle strobe: status_o/data1_o/data2_o hold a complete message
//  status_o         out  8  status byte of the message
//  data1_o          out  7  first data byte (0 if message has none)
//  data2_o          out  7  second data byte (0 if message has < 2)
//  rt_valid_o       out  1  one-cycle strobe: rt_byte_o holds a real-time byte (F8-FF)
//  rt_byte_o        out  8  real-time byte
//  drop_cnt_o       out  8  saturating count of discarded bytes
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; running status cleared.
//  Bytes are only sampled when byte_valid_i=1; other cycles change nothing except clearing strobes.
//  Real-time F8-FF (any state):
//  - rt_valid_o=1 and rt_byte_o=byte the cycle after the strobe.
//  - State, running status and partial data are untouched, incl. mid-message and in SYSEX.
//  Data-byte count by status:
//  - 2 data bytes: 8n 9n An Bn En F2.
//  - 1 data byte: Cn Dn F1 F3.
//  - No data: F6.
//  States:
//  - IDLE: no running status. Data byte -> dropped. 8n-En -> latch status, go WAIT1.
//  - RUN: channel status retained. Data byte -> becomes d1; go WAIT2 (2-byte) or emit (1-byte).
//  - WAIT1: data byte -> d1; 2-byte msg goes WAIT2; 1-byte msg emits.
//  - WAIT2: data byte -> d2; emit.
//  - SYSEX: entered on F0. All data bytes discarded, not counted as drops.
//    F7 -> IDLE, no emit. Any other non-real-time status ends sysex and is processed normally.
//  Status-byte handling:
//  - A new status byte in WAIT1/WAIT2 abandons the partial message; drop_cnt += 1 per abandoned message.
//  - F1/F2/F3 go to WAIT1 and clear running status; after the emit, next state is IDLE.
//  - F6 emits immediately and clears running status.
//  - F4, F5, F7 (outside SYSEX) -> dropped, clear running status, go IDLE.
//  - After a channel-message emit, next state is RUN.
//  Emit (registered, 1-cycle latency):
//  - msg_valid_o pulses the cycle after the completing byte's strobe.
//  - status_o/data1_o/data2_o are updated in that same cycle and held until the next emit.
//  - Unused data fields are 0.
//  - If NOTE_ON_ZERO_AS_OFF and status 9n with d2=0: status_o = 8n.
//  Simultaneity: a real-time byte and a message never complete on the same byte, so rt_valid_o
//  and msg_valid_o are never high in the same cycle.
//  drop_cnt_o:
//  - +1 per data byte dropped in IDLE, per abandoned partial message, and per F4/F5/stray F7.
//  - Saturates at 255; cleared only by reset.
//  - Dropped bytes never produce msg_valid_o.
//  Reset mid-message: the partial message is discarded and the next data byte is dropped (IDLE).
// TESTING
//  1. 90 3C 64 -> one msg_valid_o: status 90, d1 3C, d2 64; latency 1 clk after last strobe.
//  2. Running status 90 3C 64 3E 00 -> two emits; second is 80/3E/00 (NOTE_ON_ZERO_AS_OFF=1).
//  3. 90 3C F8 64 -> rt_valid_o with F8 after 3rd byte, then msg 90/3C/64; no disturbance.
//  4. C5 07 07 -> two emits C5/07/00 each; then F0 01 02 F7 45 -> no emit, drop_cnt_o=1.
//  5. 90 3C B0 07 7F -> 90 abandoned (drop_cnt_o+1), emit B0/07/7F.
//     Then F3 05 -> F3/05/00; next 06 is dropped.
//  6. 300 stray data bytes after reset -> no emits, drop_cnt_o=255.
//     Assert rst_i mid WAIT2 -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/midi_msg_parser_if.sv
// rtl/midi_msg_parser_if.sv - byte-in / message-out bus of the MIDI message parser
interface midi_msg_parser_if;
    logic       byte_valid_i;
    logic [7:0] byte_i;
    logic       msg_valid_o;
    logic [7:0] status_o;
    logic [6:0] data1_o;
    logic [6:0] data2_o;
    logic       rt_valid_o;
    logic [7:0] rt_byte_o;
    logic [7:0] drop_cnt_o;

    modport master (
        output byte_valid_i, byte_i,
        input  msg_valid_o, status_o, data1_o, data2_o, rt_valid_o, rt_byte_o, drop_cnt_o
    );

    modport slave (
        input  byte_valid_i, byte_i,
        output msg_valid_o, status_o, data1_o, data2_o, rt_valid_o, rt_byte_o, drop_cnt_o
    );
endinterface

// File: rtl/midi_msg_parser.sv
// rtl/midi_msg_parser.sv - MIDI byte stream to message assembler with running status
// Real-time bytes bypass the message FSM entirely; all outputs are registered.
module midi_msg_parser #(
  parameter bit NOTE_ON_ZERO_AS_OFF = 1'b1
) (
  input logic clk_i,
  input logic rst_i,
  midi_msg_parser_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RUN, WAIT1, WAIT2, SYSEX} state_t;

  state_t     state, state_nx;
  logic [7:0] stat, stat_nx;
  logic [6:0] d1, d1_nx;

  logic       rt_hit, is_data, is_status;
  logic       emit;
  logic [7:0] emit_status;
  logic [6:0] emit_d1, emit_d2;
  logic       abandon, stray;
  logic [1:0] drop_inc;
  logic [8:0] drop_sum;

  function automatic logic two_byte(input logic [7:0] s);
    return (s[7:4] inside {4'h8, 4'h9, 4'hA, 4'hB, 4'hE}) || (s == 8'hF2);
  endfunction

  function automatic logic channel(input logic [7:0] s);
    return s[7:4] != 4'hF;
  endfunction

  assign rt_hit    = bus.byte_valid_i && (bus.byte_i >= 8'hF8);
  assign is_data   = bus.byte_valid_i && !bus.byte_i[7];
  assign is_status = bus.byte_valid_i && bus.byte_i[7] && (bus.byte_i < 8'hF8);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      stat  <= 8'h00;
      d1    <= 7'h00;
    end else begin
      state <= state_nx;
      stat  <= stat_nx;
      d1    <= d1_nx;
    end
  end

  always_comb begin
    state_nx = state;
    stat_nx  = stat;
    d1_nx    = d1;
    if (is_data) begin
      case (state)
        RUN, WAIT1: begin
          d1_nx = bus.byte_i[6:0];
          if (two_byte(stat))
            state_nx = WAIT2;
          else
            state_nx = channel(stat) ? RUN : IDLE;
        end
        WAIT2:   state_nx = channel(stat) ? RUN : IDLE;
        default: state_nx = state;
      endcase
    end else if (is_status) begin
      if (state == SYSEX && bus.byte_i == 8'hF7) begin
        state_nx = IDLE;
      end else if (bus.byte_i < 8'hF0 || bus.byte_i inside {8'hF1, 8'hF2, 8'hF3}) begin
        stat_nx  = bus.byte_i;
        state_nx = WAIT1;
      end else if (bus.byte_i == 8'hF0) begin
        state_nx = SYSEX;
      end else begin
        state_nx = IDLE;
      end
    end
  end

  always_comb begin
    emit        = 1'b0;
    emit_status = stat;
    emit_d1     = 7'h00;
    emit_d2     = 7'h00;
    if (is_status && bus.byte_i == 8'hF6) begin
      emit        = 1'b1;
      emit_status = 8'hF6;
    end else if (is_data) begin
      if (state == WAIT2) begin
        emit    = 1'b1;
        emit_d1 = d1;
        emit_d2 = bus.byte_i[6:0];
      end else if ((state == RUN || state == WAIT1) && !two_byte(stat)) begin
        emit    = 1'b1;
        emit_d1 = bus.byte_i[6:0];
      end
    end
    // Running status keeps 9n; only the emitted copy becomes a note-off.
    if (NOTE_ON_ZERO_AS_OFF && emit_status[7:4] == 4'h9 && emit_d2 == 7'h00)
      emit_status = {4'h8, emit_status[3:0]};

    abandon  = is_status && (state == WAIT1 || state == WAIT2);
    stray    = is_status && (bus.byte_i inside {8'hF4, 8'hF5} ||
                             (bus.byte_i == 8'hF7 && state != SYSEX));
    drop_inc = (is_data && state == IDLE) ? 2'd1
                                          : ({1'b0, abandon} + {1'b0, stray});
    drop_sum = {1'b0, bus.drop_cnt_o} + {7'b0, drop_inc};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.msg_valid_o <= 1'b0;
      bus.status_o    <= 8'h00;
      bus.data1_o     <= 7'h00;
      bus.data2_o     <= 7'h00;
      bus.rt_valid_o  <= 1'b0;
      bus.rt_byte_o   <= 8'h00;
      bus.drop_cnt_o  <= 8'h00;
    end else begin
      bus.msg_valid_o <= emit;
      bus.rt_valid_o  <= rt_hit;
      bus.drop_cnt_o  <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (emit) begin
        bus.status_o <= emit_status;
        bus.data1_o  <= emit_d1;
        bus.data2_o  <= emit_d2;
      end
      if (rt_hit)
        bus.rt_byte_o <= bus.byte_i;
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// tb/tb_midi_msg_parser.sv - directed self-checking bench for midi_msg_parser
module tb_midi_msg_parser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  midi_msg_parser_if bus ();
  midi_msg_parser #(.NOTE_ON_ZERO_AS_OFF(1'b1)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.byte_valid_i = 1'b1;
    bus.byte_i       = b;
    @(negedge clk);
    bus.byte_valid_i = 1'b0;
    bus.byte_i       = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.byte_valid_i = 1'b0;
    bus.byte_i       = 8'h00;
    rst = 1'b1;
    #2;
    total_cnt++;
    if ({bus.msg_valid_o, bus.status_o, bus.data1_o, bus.data2_o, bus.rt_valid_o, bus.rt_byte_o, bus.drop_cnt_o} !== 40'h0)
      $display("FAIL reset_outputs got msg=%0b st=%h d1=%h d2=%h rt=%0b rtb=%h drop=%0d want all 0",
               bus.msg_valid_o, bus.status_o, bus.data1_o, bus.data2_o, bus.rt_valid_o, bus.rt_byte_o, bus.drop_cnt_o);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_note_on();
    send(8'h90); send(8'h3C);
    total_cnt++;
    if (bus.msg_valid_o !== 1'b0) $display("FAIL note_on_early got %0b want 0", bus.msg_valid_o); else pass_cnt++;
    send(8'h64);
    total_cnt++;
    if ({bus.msg_valid_o, bus.status_o, bus.data1_o, bus.data2_o} !== {1'b1, 8'h90, 7'h3C, 7'h64})
      $display("FAIL note_on_emit got v=%0b %h/%h/%h want 1 90/3c/64", bus.msg_valid_o, bus.status_o, bus.data1_o, bus.data2_o);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({bus.msg_valid_o, bus.status_o} !== {1'b0, 8'h90})
      $display("FAIL note_on_hold got v=%0b st=%h want 0 90", bus.msg_valid_o, bus.status_o); else pass_cnt++;
  endtask

  task automatic test_running_status();
    send(8'h3E);
    total_cnt++;
    if (bus.msg_valid_o !== 1'b0) $display("FAIL running_mid got %0b want 0", bus.msg_valid_o); else pass_cnt++;
    send(8'h00);
    total_cnt++;
    if ({bus.msg_valid_o, bus.status_o, bus.data1_o, bus.data2_o} !== {1'b1, 8'h80, 7'h3E, 7'h00})
      $display("FAIL running_note_off got v=%0b %h/%h/%h want 1 80/3e/00", bus.msg_valid_o, bus.status_o, bus.data1_o, bus.data2_o);
    else pass_cnt++;
  endtask

  task automatic test_realtime();
    send(8'h90); send(8'h3C); send(8'hF8);
    total_cnt++;
    if ({bus.rt_valid_o, bus.rt_byte_o, bus.msg_valid_o} !== {1'b1, 8'hF8, 1'b0})
      $display("FAIL rt_pass got rt=%0b b=%h msg=%0b want 1 f8 0", bus.rt_valid_o, bus.rt_byte_o, bus.msg_valid_o);
    else pass_cnt++;
    send(8'h64);
    total_cnt++;
    if ({bus.msg_valid_o, bus.rt_valid_o, bus.status_o, bus.data1_o, bus.data2_o} !== {2'b10, 8'h90, 7'h3C, 7'h64})
      $display("FAIL rt_msg_after got v=%0b rt=%0b %h/%h/%h want 1 0 90/3c/64",
               bus.msg_valid_o, bus.rt_valid_o, bus.status_o, bus.data1_o, bus.data2_o);
    else pass_cnt++;
  endtask

  task automatic test_one_byte_sysex();
    do_reset();
    send(8'hC5); send(8'h07);
    total_cnt++;
    if ({bus.msg_valid_o, bus.status_o, bus.data1_o, bus.data2_o} !== {1'b1, 8'hC5, 7'h07, 7'h00})
      $display("FAIL prog_first got v=%0b %h/%h/%h want 1 c5/07/00", bus.msg_valid_o, bus.status_o, bus.data1_o, bus.data2_o);
    else pass_cnt++;
    send(8'h07);
    total_cnt++;
    if ({bus.msg_valid_o, bus.status_o, bus.data1_o, bus.data2_o} !== {1'b1, 8'hC5, 7'h07, 7'h00})
      $display("FAIL prog_running got v=%0b %h/%h/%h want 1 c5/07/00", bus.msg_valid_o, bus.status_o, bus.data1_o, bus.data2_o);
    else pass_cnt++;
    send(8'hF0); send(8'h01); send(8'h02); send(8'hF7);
    total_cnt++;
    if ({bus.msg_valid_o, bus.drop_cnt_o} !== {1'b0, 8'd0})
      $display("FAIL sysex_quiet got v=%0b drop=%0d want 0 0", bus.msg_valid_o, bus.drop_cnt_o); else pass_cnt++;
    send(8'h45);
    total_cnt++;
    if ({bus.msg_valid_o, bus.drop_cnt_o} !== {1'b0, 8'd1})
      $display("FAIL post_sysex_drop got v=%0b drop=%0d want 0 1", bus.msg_valid_o, bus.drop_cnt_o); else pass_cnt++;
  endtask

  task automatic test_abandon_common();
    do_reset();
    send(8'h90); send(8'h3C); send(8'hB0); send(8'h07); send(8'h7F);
    total_cnt++;
    if ({bus.msg_valid_o, bus.status_o, bus.data1_o, bus.data2_o, bus.drop_cnt_o} !== {1'b1, 8'hB0, 7'h07, 7'h7F, 8'd1})
      $display("FAIL abandon_cc got v=%0b %h/%h/%h drop=%0d want 1 b0/07/7f 1",
               bus.msg_valid_o, bus.status_o, bus.data1_o, bus.data2_o, bus.drop_cnt_o);
    else pass_cnt++;
    send(8'hF3); send(8'h05);
    total_cnt++;
    if ({bus.msg_valid_o, bus.status_o, bus.data1_o, bus.data2_o} !== {1'b1, 8'hF3, 7'h05, 7'h00})
      $display("FAIL song_select got v=%0b %h/%h/%h want 1 f3/05/00", bus.msg_valid_o, bus.status_o, bus.data1_o, bus.data2_o);
    else pass_cnt++;
    send(8'h06);
    total_cnt++;
    if ({bus.msg_valid_o, bus.drop_cnt_o} !== {1'b0, 8'd2})
      $display("FAIL after_common_drop got v=%0b drop=%0d want 0 2", bus.msg_valid_o, bus.drop_cnt_o); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    send(8'hF6);
    total_cnt++;
    if ({bus.msg_valid_o, bus.status_o, bus.data1_o, bus.data2_o} !== {1'b1, 8'hF6, 7'h00, 7'h00})
      $display("FAIL tune_req got v=%0b %h/%h/%h want 1 f6/00/00", bus.msg_valid_o, bus.status_o, bus.data1_o, bus.data2_o);
    else pass_cnt++;
    send(8'hA2); send(8'hF4);
    total_cnt++;
    if ({bus.msg_valid_o, bus.drop_cnt_o} !== {1'b0, 8'd4})
      $display("FAIL f4_on_partial got v=%0b drop=%0d want 0 4", bus.msg_valid_o, bus.drop_cnt_o); else pass_cnt++;
  endtask

  task automatic test_saturate_reset();
    int emits;
    emits = 0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send(8'(i % 128));
      if (bus.msg_valid_o) emits++;
    end
    total_cnt++;
    if (emits !== 0) $display("FAIL stray_emits got %0d want 0", emits); else pass_cnt++;
    total_cnt++;
    if (bus.drop_cnt_o !== 8'd255) $display("FAIL drop_saturate got %0d want 255", bus.drop_cnt_o); else pass_cnt++;
    send(8'h91); send(8'h22); send(8'h33);
    total_cnt++;
    if ({bus.msg_valid_o, bus.status_o, bus.data1_o, bus.data2_o} !== {1'b1, 8'h91, 7'h22, 7'h33})
      $display("FAIL pre_reset_msg got v=%0b %h/%h/%h want 1 91/22/33", bus.msg_valid_o, bus.status_o, bus.data1_o, bus.data2_o);
    else pass_cnt++;
    send(8'h91); send(8'h22);
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({bus.msg_valid_o, bus.status_o, bus.data1_o, bus.data2_o, bus.rt_valid_o, bus.rt_byte_o, bus.drop_cnt_o} !== 40'h0)
      $display("FAIL async_reset got st=%h d1=%h d2=%h drop=%0d want all 0",
               bus.status_o, bus.data1_o, bus.data2_o, bus.drop_cnt_o);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    send(8'h40);
    total_cnt++;
    if ({bus.msg_valid_o, bus.drop_cnt_o} !== {1'b0, 8'd1})
      $display("FAIL post_reset_drop got v=%0b drop=%0d want 0 1", bus.msg_valid_o, bus.drop_cnt_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime();
    test_one_byte_sysex();
    test_abandon_common();
    test_back_to_back();
    test_saturate_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
